hazard_ctrl: RTL and testbench

- Central pipeline controller that drives the stall_i/flush_i inputs of the pipeline registers (if2id, id2exe, exe2mem, mem2wb) and the PC hold.
- Resolves four hazard sources: load-use and branch-operand data hazards, the multi-cycle divider, I/D-memory wait states, and exception/ERET redirection.
- Sits beside the datapath and is purely the control end of the stall/flush interface. Pipeline registers give flush priority over stall.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/hz_match.sv | 19 +
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: hazard FSM states and the packed stall/flush
// vector that other control blocks (cp0, tlb) can drive the same way.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_if2id;
    logic stall_id2exe;
    logic stall_exe2mem;
    logic flush_if2id;
    logic flush_id2exe;
    logic flush_exe2mem;
    logic flush_mem2wb;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t PIPE_CTRL_NONE = '0;

endpackage

// File: rtl/hz_match.sv
// Operand-match unit: flags an ID source register that equals a producer's
// destination. Register 0 is hardwired and never creates a dependency.
module hz_match (
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       use_rs_i,
  input  logic       use_rt_i,
  input  logic [4:0] dst_i,
  output logic       hit_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = use_rs_i && (rs_i != 5'd0) && (rs_i == dst_i);
  assign rt_hit = use_rt_i && (rt_i != 5'd0) && (rt_i == dst_i);
  assign hit_o  = rs_hit || rt_hit;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritises exceptions, D-memory waits, the
// multi-cycle divider, data hazards and I-fetch waits into stall/flush controls.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_use_rs_i,
  input  logic       id_use_rt_i,
  input  logic       id_branch_i,
  input  logic [4:0] exe_dst_i,
  input  logic       exe_wreg_i,
  input  logic       exe_rmem_i,
  input  logic       exe_div_i,
  input  logic [4:0] mem_dst_i,
  input  logic       mem_rmem_i,
  input  logic       imem_stall_i,
  input  logic       dmem_stall_i,
  input  logic       except_i,
  output logic       stall_pc_o,
  output logic       stall_if2id_o,
  output logic       stall_id2exe_o,
  output logic       stall_exe2mem_o,
  output logic       flush_if2id_o,
  output logic       flush_id2exe_o,
  output logic       flush_exe2mem_o,
  output logic       flush_mem2wb_o,
  output logic       div_done_o,
  output logic       div_busy_o
);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pipe_ctrl_t       ctrl;
  logic             exe_hit, mem_hit;
  logic             load_use, br_haz, div_stall;

  hz_match u_exe_match (
    .rs_i     (id_rs_i),
    .rt_i     (id_rt_i),
    .use_rs_i (id_use_rs_i),
    .use_rt_i (id_use_rt_i),
    .dst_i    (exe_dst_i),
    .hit_o    (exe_hit)
  );

  hz_match u_mem_match (
    .rs_i     (id_rs_i),
    .rt_i     (id_rt_i),
    .use_rs_i (id_use_rs_i),
    .use_rt_i (id_use_rt_i),
    .dst_i    (mem_dst_i),
    .hit_o    (mem_hit)
  );

  assign load_use  = exe_rmem_i && exe_hit;
  assign br_haz    = id_branch_i && ((exe_wreg_i && exe_hit) || (mem_rmem_i && mem_hit));
  assign div_stall = ((state_q == IDLE) && exe_div_i) || (state_q == DIV_BUSY);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The divide counter keeps running through D-memory waits; only DIV_DONE waits them out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (except_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (exe_div_i) begin
            state_d = DIV_BUSY;
            cnt_d   = CNT_W'(DIV_CYCLES - 1);
          end
        end
        DIV_BUSY: begin
          if (cnt_q == '0) state_d = DIV_DONE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        DIV_DONE: begin
          if (!dmem_stall_i) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    ctrl = PIPE_CTRL_NONE;
    if (!rst_i) begin
      ctrl = PIPE_CTRL_NONE;
    end else if (except_i) begin
      ctrl.flush_if2id   = 1'b1;
      ctrl.flush_id2exe  = 1'b1;
      ctrl.flush_exe2mem = 1'b1;
      ctrl.flush_mem2wb  = 1'b1;
    end else if (dmem_stall_i) begin
      ctrl.stall_pc      = 1'b1;
      ctrl.stall_if2id   = 1'b1;
      ctrl.stall_id2exe  = 1'b1;
      ctrl.stall_exe2mem = 1'b1;
      ctrl.flush_mem2wb  = 1'b1;
    end else if (div_stall) begin
      ctrl.stall_pc      = 1'b1;
      ctrl.stall_if2id   = 1'b1;
      ctrl.stall_id2exe  = 1'b1;
      ctrl.flush_exe2mem = 1'b1;
    end else if (load_use || br_haz) begin
      ctrl.stall_pc      = 1'b1;
      ctrl.stall_if2id   = 1'b1;
      ctrl.flush_id2exe  = 1'b1;
    end else if (imem_stall_i) begin
      ctrl.stall_pc      = 1'b1;
      ctrl.flush_if2id   = 1'b1;
    end
  end

  assign stall_pc_o      = ctrl.stall_pc;
  assign stall_if2id_o   = ctrl.stall_if2id;
  assign stall_id2exe_o  = ctrl.stall_id2exe;
  assign stall_exe2mem_o = ctrl.stall_exe2mem;
  assign flush_if2id_o   = ctrl.flush_if2id;
  assign flush_id2exe_o  = ctrl.flush_id2exe;
  assign flush_exe2mem_o = ctrl.flush_exe2mem;
  assign flush_mem2wb_o  = ctrl.flush_mem2wb;
  assign div_done_o      = rst_i && (state_q == DIV_DONE);
  assign div_busy_o      = rst_i && (state_q == DIV_BUSY);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with DIV_CYCLES=4; outputs are compared as
// a 10-bit vector {stalls, flushes, div_done, div_busy} one cycle at a time.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, exe_dst = '0, mem_dst = '0;
  logic       use_rs = 0, use_rt = 0, branch = 0, exe_wreg = 0, exe_rmem = 0;
  logic       exe_div = 0, mem_rmem = 0, imem_stall = 0, dmem_stall = 0, except_in = 0;
  logic       s_pc, s_if2id, s_id2exe, s_exe2mem;
  logic       f_if2id, f_id2exe, f_exe2mem, f_mem2wb, div_done, div_busy;

  int checks = 0;
  int fails  = 0;

  // {stall pc,if2id,id2exe,exe2mem | flush if2id,id2exe,exe2mem,mem2wb | done,busy}
  localparam logic [9:0] NONE  = 10'b0000_0000_00;
  localparam logic [9:0] LU    = 10'b1100_0100_00;
  localparam logic [9:0] IMS   = 10'b1000_1000_00;
  localparam logic [9:0] DVS   = 10'b1110_0010_00;
  localparam logic [9:0] DVB   = 10'b1110_0010_01;
  localparam logic [9:0] DONE  = 10'b0000_0000_10;
  localparam logic [9:0] DMB   = 10'b1111_0001_01;
  localparam logic [9:0] DMD   = 10'b1111_0001_10;
  localparam logic [9:0] EXB   = 10'b0000_1111_01;

  hazard_ctrl #(.DIV_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rs_i(use_rs), .id_use_rt_i(use_rt),
    .id_branch_i(branch), .exe_dst_i(exe_dst), .exe_wreg_i(exe_wreg),
    .exe_rmem_i(exe_rmem), .exe_div_i(exe_div), .mem_dst_i(mem_dst),
    .mem_rmem_i(mem_rmem), .imem_stall_i(imem_stall), .dmem_stall_i(dmem_stall),
    .except_i(except_in),
    .stall_pc_o(s_pc), .stall_if2id_o(s_if2id), .stall_id2exe_o(s_id2exe),
    .stall_exe2mem_o(s_exe2mem), .flush_if2id_o(f_if2id), .flush_id2exe_o(f_id2exe),
    .flush_exe2mem_o(f_exe2mem), .flush_mem2wb_o(f_mem2wb),
    .div_done_o(div_done), .div_busy_o(div_busy)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    #1;
    obs = {s_pc, s_if2id, s_id2exe, s_exe2mem, f_if2id, f_id2exe, f_exe2mem, f_mem2wb,
           div_done, div_busy};
    checks++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
    $display("t=%0t %-14s obs=%b exp=%b", $time, tag, obs, exp);
  endtask

  task automatic chk_cnt(input string tag, input logic [1:0] exp);
    checks++;
    assert (dut.cnt_q === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0d expected=%0d", tag, dut.cnt_q, exp);
      end
    $display("t=%0t %-14s cnt=%0d exp=%0d", $time, tag, dut.cnt_q, exp);
  endtask

  task automatic clr();
    id_rs = '0; id_rt = '0; exe_dst = '0; mem_dst = '0;
    use_rs = 0; use_rt = 0; branch = 0; exe_wreg = 0; exe_rmem = 0;
    exe_div = 0; mem_rmem = 0; imem_stall = 0; dmem_stall = 0; except_in = 0;
  endtask

  initial begin
    // Reset forces every output low, even with active hazard sources
    nxt(); imem_stall = 1; except_in = 1; exe_div = 1; chk("rst_force", NONE);
    nxt(); rst = 1; clr(); chk("idle", NONE);

    // Load-use on rs
    nxt(); exe_rmem = 1; exe_dst = 5; id_rs = 5; use_rs = 1; chk("loaduse", LU);
    nxt(); exe_rmem = 0; chk("loaduse_gone", NONE);
    nxt(); exe_rmem = 1; exe_dst = 0; id_rs = 0; chk("loaduse_r0", NONE);
    nxt(); exe_dst = 9; id_rs = 9; use_rs = 0; chk("loaduse_nouse", NONE);
    nxt(); clr(); exe_rmem = 1; exe_dst = 3; id_rt = 3; use_rt = 1; chk("loaduse_rt", LU);

    // Branch operand hazards against EXE then MEM
    nxt(); clr(); branch = 1; id_rt = 7; use_rt = 1; exe_wreg = 1; exe_dst = 7;
    chk("br_exe", LU);
    nxt(); exe_wreg = 0; mem_rmem = 1; mem_dst = 7; chk("br_mem", LU);
    nxt(); mem_rmem = 0; chk("br_clear", NONE);
    nxt(); branch = 0; exe_wreg = 1; exe_dst = 7; chk("alu_no_branch", NONE);

    // I-fetch wait alone, then combined with a load-use
    nxt(); clr(); imem_stall = 1; chk("imem", IMS);
    nxt(); exe_rmem = 1; exe_dst = 4; id_rs = 4; use_rs = 1; chk("imem_lu", LU);

    // Plain divide: 1 start + 4 busy cycles stalled, then DIV_DONE, then IDLE
    nxt(); clr(); exe_div = 1; chk("div_start", DVS);
    nxt(); chk("div_busy1", DVB);
    nxt(); imem_stall = 1; chk("div_busy2_im", DVB);
    nxt(); imem_stall = 0; chk("div_busy3", DVB);
    nxt(); chk("div_busy4", DVB);
    nxt(); chk("div_done", DONE);
    nxt(); exe_div = 0; chk("div_idle", NONE);

    // Divide with a D-miss from busy cycle 2 through cycle 10
    nxt(); exe_div = 1; chk("dm_start", DVS);
    nxt(); chk("dm_busy1", DVB);
    nxt(); dmem_stall = 1; chk("dm_busy2", DMB);
    nxt(); chk("dm_busy3", DMB);
    nxt(); chk("dm_busy4", DMB);
    for (int i = 5; i <= 10; i++) begin
      nxt(); chk($sformatf("dm_done_c%0d", i), DMD);
    end
    nxt(); dmem_stall = 0; chk("dm_done_free", DONE);
    nxt(); exe_div = 0; chk("dm_idle", NONE);

    // Exception at busy cycle 2 (with a D-miss pending) aborts the divide
    nxt(); exe_div = 1; chk("ex_start", DVS);
    nxt(); chk("ex_busy1", DVB);
    nxt(); except_in = 1; dmem_stall = 1; chk("ex_flush", EXB);
    nxt(); clr(); chk("ex_after", NONE);
    chk_cnt("ex_cnt", 2'd0);

    // Reset during DIV_BUSY
    nxt(); exe_div = 1; chk("rb_start", DVS);
    nxt(); chk("rb_busy1", DVB);
    nxt(); rst = 0; chk("rb_rst", NONE);
    nxt(); rst = 1; exe_div = 0; chk("rb_after", NONE);

    // Back-to-back divides: the second restarts from IDLE
    nxt(); exe_div = 1; chk("bb_start", DVS);
    for (int i = 1; i <= 4; i++) begin
      nxt(); chk($sformatf("bb_busy%0d", i), DVB);
    end
    nxt(); chk("bb_done", DONE);
    nxt(); chk("bb_restart", DVS);
    nxt(); exe_div = 0; chk("bb_busy_again", DVB);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
